// File: rtl/wavetable_pkg.sv
// Shared types and constants for the wavetable voice scheduler: note scale
// table, sweep FSM states, phase update modes and the codec byte-swap helper.
package wavetable_pkg;

    localparam int NOTE_MAX  = 12;
    localparam int NUM_NOTES = NOTE_MAX + 1;

    typedef logic [7:0] scale_t;

    // Phase increment per sample frame for each note index 0..12.
    localparam scale_t SCALE_TABLE [NUM_NOTES] = '{
        8'd74,  8'd78,  8'd83,  8'd88,  8'd93,  8'd99, 8'd104,
        8'd111, 8'd117, 8'd124, 8'd132, 8'd139, 8'd148
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACCUM,
        ST_NEXT,
        ST_FINISH
    } sched_state_e;

    typedef enum logic [1:0] {
        PH_HOLD  = 2'd0,
        PH_ADD   = 2'd1,
        PH_CLEAR = 2'd2
    } phase_mode_e;

    // dpram_ctrl delivers little-endian words; the mix path wants big-endian.
    function automatic logic [15:0] byte_swap(input logic [15:0] word);
        return {word[7:0], word[15:8]};
    endfunction

    function automatic scale_t note_scale(input logic [3:0] note);
        return (note <= 4'(NOTE_MAX)) ? SCALE_TABLE[note] : 8'd0;
    endfunction

endpackage

// File: rtl/voice_phase_bank.sv
// Per-voice phase accumulators: one indexed read port for address generation
// and one update port that adds a scale, clears, or holds a single voice.
module voice_phase_bank
    import wavetable_pkg::*;
#(
    parameter  int NUM_VOICES = 4,
    parameter  int POS_W      = 13,
    localparam int VIDX_W     = $clog2(NUM_VOICES)
) (
    input  logic              clk_50,
    input  logic              daclrck,
    input  logic [VIDX_W-1:0] rd_idx_i,
    output logic [POS_W-1:0]  rd_pos_o,
    input  logic              upd_en_i,
    input  logic [VIDX_W-1:0] upd_idx_i,
    input  logic [1:0]        upd_mode_i,
    input  logic [7:0]        upd_scale_i
);

    logic [POS_W-1:0] pos_q [NUM_VOICES];

    assign rd_pos_o = pos_q[rd_idx_i];

    // NOTE: the position array is small register state, not a RAM, so it is
    // reset explicitly; every voice must start from phase 0 after reset.
    always_ff @(posedge clk_50 or posedge daclrck) begin
        if (daclrck) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                pos_q[i] <= '0;
            end
        end else if (upd_en_i) begin
            case (phase_mode_e'(upd_mode_i))
                PH_ADD:   pos_q[upd_idx_i] <= pos_q[upd_idx_i] + POS_W'(upd_scale_i);
                PH_CLEAR: pos_q[upd_idx_i] <= '0;
                default:  pos_q[upd_idx_i] <= pos_q[upd_idx_i];
            endcase
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// Sweeps NUM_VOICES wavetable voices over the shared dpram_ctrl read port
// once per sample_tick and emits one saturated 16-bit mix per frame.
module voice_scheduler
    import wavetable_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int POS_W      = 13,
    parameter int TIMEOUT    = 63
) (
    input  logic                    clk_50,
    input  logic                    daclrck,
    input  logic                    sample_tick,
    input  logic [NUM_VOICES-1:0]   key_on,
    input  logic [4*NUM_VOICES-1:0] key_val,
    input  logic [2*NUM_VOICES-1:0] wave_sel,
    output logic [POS_W+1:0]        mem_addr,
    output logic                    mem_rd,
    input  logic                    mem_done,
    input  logic [15:0]             mem_dout,
    output logic [15:0]             mix_out,
    output logic                    mix_valid,
    output logic                    busy,
    output logic                    overrun,
    output logic                    mem_timeout
);

    localparam int VIDX_W = $clog2(NUM_VOICES);
    localparam int ACC_W  = 16 + VIDX_W;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    localparam logic signed [ACC_W-1:0] MIX_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MIX_MIN = ACC_W'(-32768);

    sched_state_e            state_q;
    logic [VIDX_W-1:0]       v_q;
    logic [NUM_VOICES-1:0]   key_on_q;
    logic [4*NUM_VOICES-1:0] key_val_q;
    logic [2*NUM_VOICES-1:0] wave_sel_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [15:0]             s_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [POS_W+1:0]        mem_addr_q;
    logic                    mem_rd_q;
    logic [15:0]             mix_out_q;
    logic                    mix_valid_q;
    logic                    busy_q;
    logic                    overrun_q;
    logic                    mem_timeout_q;

    // Current voice, decoded from the frame snapshot.
    logic [3:0]       cur_key_val;
    logic [1:0]       cur_wave;
    logic             cur_on;
    logic             cur_active;
    logic [POS_W-1:0] cur_pos;
    logic [1:0]       cur_mode;
    logic [15:0]      sat_mix;

    assign cur_key_val = key_val_q[{v_q, 2'b00} +: 4];
    assign cur_wave    = wave_sel_q[{v_q, 1'b0} +: 2];
    assign cur_on      = key_on_q[v_q];
    assign cur_active  = cur_on && (cur_key_val <= 4'(NOTE_MAX));
    assign cur_mode    = !cur_on     ? PH_CLEAR :
                         cur_active  ? PH_ADD   : PH_HOLD;

    assign sat_mix = (acc_q > MIX_MAX) ? 16'h7FFF :
                     (acc_q < MIX_MIN) ? 16'h8000 : acc_q[15:0];

    voice_phase_bank #(
        .NUM_VOICES (NUM_VOICES),
        .POS_W      (POS_W)
    ) u_phase_bank (
        .clk_50      (clk_50),
        .daclrck     (daclrck),
        .rd_idx_i    (v_q),
        .rd_pos_o    (cur_pos),
        .upd_en_i    (state_q == ST_NEXT),
        .upd_idx_i   (v_q),
        .upd_mode_i  (cur_mode),
        .upd_scale_i (note_scale(cur_key_val))
    );

    // NOTE: every register here is written with non-blocking assignments so
    // all state advances together on the clock edge, independent of order.
    always_ff @(posedge clk_50 or posedge daclrck) begin
        if (daclrck) begin
            state_q       <= ST_IDLE;
            v_q           <= '0;
            key_on_q      <= '0;
            key_val_q     <= '0;
            wave_sel_q    <= '0;
            acc_q         <= '0;
            s_q           <= '0;
            cnt_q         <= '0;
            mem_addr_q    <= '0;
            mem_rd_q      <= 1'b0;
            mix_out_q     <= '0;
            mix_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            mem_rd_q    <= 1'b0;
            mix_valid_q <= 1'b0;

            // A tick during a sweep is dropped but remembered.
            if (sample_tick && busy_q) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (sample_tick) begin
                        key_on_q   <= key_on;
                        key_val_q  <= key_val;
                        wave_sel_q <= wave_sel;
                        acc_q      <= '0;
                        v_q        <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cur_active) begin
                        mem_addr_q <= {cur_wave, cur_pos};
                        mem_rd_q   <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= ST_WAIT;
                    end else begin
                        state_q    <= ST_NEXT;
                    end
                end
                ST_WAIT: begin
                    if (mem_done) begin
                        s_q     <= byte_swap(mem_dout);
                        state_q <= ST_ACCUM;
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        s_q           <= '0;
                        mem_timeout_q <= 1'b1;
                        state_q       <= ST_ACCUM;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ACCUM: begin
                    acc_q   <= acc_q + {{VIDX_W{s_q[15]}}, s_q};
                    state_q <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (v_q == VIDX_W'(NUM_VOICES - 1)) begin
                        mix_out_q   <= sat_mix;
                        mix_valid_q <= 1'b1;
                        state_q     <= ST_FINISH;
                    end else begin
                        v_q     <= v_q + 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign mix_out     = mix_out_q;
    assign mix_valid   = mix_valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Scoreboard bench for voice_scheduler: a frame model pushes expected read
// addresses and mix samples; monitors pop and compare as the DUT produces them.
module tb_voice_scheduler;

    localparam int NV = 4;

    logic        clk_50 = 1'b0;
    logic        daclrck;
    logic        sample_tick;
    logic [3:0]  key_on;
    logic [15:0] key_val;
    logic [7:0]  wave_sel;
    logic [14:0] mem_addr;
    logic        mem_rd;
    logic        mem_done;
    logic [15:0] mem_dout;
    logic [15:0] mix_out;
    logic        mix_valid;
    logic        busy;
    logic        overrun;
    logic        mem_timeout;

    voice_scheduler #(.NUM_VOICES(4), .POS_W(13), .TIMEOUT(63)) dut (
        .clk_50      (clk_50),
        .daclrck     (daclrck),
        .sample_tick (sample_tick),
        .key_on      (key_on),
        .key_val     (key_val),
        .wave_sel    (wave_sel),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_done    (mem_done),
        .mem_dout    (mem_dout),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .busy        (busy),
        .overrun     (overrun),
        .mem_timeout (mem_timeout)
    );

    always #10 clk_50 = ~clk_50;

    int checks = 0;
    int errors = 0;
    int rd_count = 0;
    int mv_count = 0;
    int mem_delay = 2;

    int          scale_m [13] = '{74, 78, 83, 88, 93, 99, 104, 111, 117, 124, 132, 139, 148};
    int          model_pos [NV];
    logic [15:0] tb_dout [NV];
    logic [3:0]  tb_nodone;

    logic [14:0] exp_addr_q [$];
    logic [15:0] exp_mix_q [$];
    logic [16:0] mem_q [$];
    logic [14:0] exp_a;
    logic [15:0] exp_m;

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk_50) begin
        if (daclrck === 1'b0) begin
            if (mem_rd === 1'b1) begin
                rd_count++;
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected got addr %h want no read", mem_addr);
                end else begin
                    exp_a = exp_addr_q.pop_front();
                    if (mem_addr !== exp_a) begin
                        errors++;
                        $display("FAIL mem_addr got %h want %h", mem_addr, exp_a);
                    end
                end
            end
            if (mix_valid === 1'b1) begin
                mv_count++;
                checks++;
                if (exp_mix_q.size() == 0) begin
                    errors++;
                    $display("FAIL mix_valid_unexpected got mix %h want no pulse", mix_out);
                end else begin
                    exp_m = exp_mix_q.pop_front();
                    if (mix_out !== exp_m) begin
                        errors++;
                        $display("FAIL mix_out got %h want %h", mix_out, exp_m);
                    end
                end
            end
        end
    end

    // Memory model: answers each read after mem_delay cycles unless flagged silent.
    initial begin
        logic [16:0] ent;
        mem_done = 1'b0;
        mem_dout = 16'h0;
        forever begin
            @(posedge clk_50);
            #1;
            if (mem_rd === 1'b1) begin
                ent = (mem_q.size() == 0) ? 17'h10000 : mem_q.pop_front();
                if (!ent[16]) begin
                    repeat (mem_delay) @(posedge clk_50);
                    #1;
                    mem_done = 1'b1;
                    mem_dout = ent[15:0];
                    @(posedge clk_50);
                    #1;
                    mem_done = 1'b0;
                end
            end
        end
    end

    task automatic model_frame();
        int               sum;
        logic [3:0]       kv;
        logic [15:0]      raw;
        logic signed [15:0] smp;
        sum = 0;
        for (int v = 0; v < NV; v++) begin
            kv = key_val[4*v +: 4];
            if (key_on[v] && kv <= 4'd12) begin
                exp_addr_q.push_back({wave_sel[2*v +: 2], 13'(model_pos[v])});
                mem_q.push_back({tb_nodone[v], tb_dout[v]});
                raw = tb_dout[v];
                smp = {raw[7:0], raw[15:8]};
                if (!tb_nodone[v]) sum += int'(smp);
                model_pos[v] = (model_pos[v] + scale_m[kv]) % 8192;
            end else if (!key_on[v]) begin
                model_pos[v] = 0;
            end
        end
        if (sum > 32767)       exp_mix_q.push_back(16'h7FFF);
        else if (sum < -32768) exp_mix_q.push_back(16'h8000);
        else                   exp_mix_q.push_back(16'(sum));
    endtask

    task automatic pulse_tick(input int retick);
        @(posedge clk_50); #1 sample_tick = 1'b1;
        @(posedge clk_50); #1 sample_tick = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_sweep got %b want 1", busy);
        end
        if (retick > 0) begin
            @(posedge clk_50); #1 sample_tick = 1'b1;
            @(posedge clk_50); #1 sample_tick = 1'b0;
        end
    endtask

    task automatic wait_mix(input int start);
        for (int i = 0; i < 3000 && mv_count == start; i++) @(posedge clk_50);
        checks++;
        if (mv_count == start) begin
            errors++;
            $display("FAIL frame_done got no mix_valid want one within 3000 cycles");
        end
        repeat (2) @(posedge clk_50);
        #1;
    endtask

    task automatic do_frame(input int retick);
        int start;
        start = mv_count;
        model_frame();
        pulse_tick(retick);
        wait_mix(start);
    endtask

    task automatic test_reset();
        daclrck = 1'b1;
        repeat (3) @(posedge clk_50);
        #1 daclrck = 1'b0;
        repeat (5) @(posedge clk_50);
        #1;
        checks++;
        if ({mem_rd, mix_valid, busy, overrun, mem_timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000", {mem_rd, mix_valid, busy, overrun, mem_timeout});
        end
        checks++;
        if (mix_out !== 16'h0) begin
            errors++;
            $display("FAIL reset_mix got %h want 0000", mix_out);
        end
        checks++;
        if (mem_addr !== 15'h0) begin
            errors++;
            $display("FAIL reset_addr got %h want 0000", mem_addr);
        end
    endtask

    task automatic test_single_voice();
        key_on = 4'b0001; key_val = 16'h0000; wave_sel = 8'b0000_0001;
        tb_dout[0] = 16'h3412; mem_delay = 2;
        do_frame(0);
        checks++;
        if (mix_valid !== 1'b0) begin
            errors++;
            $display("FAIL mix_valid_width got %b want 0", mix_valid);
        end
        checks++;
        if (mem_addr !== 15'h2000 || mix_out !== 16'h1234) begin
            errors++;
            $display("FAIL single_hold got addr %h mix %h want 2000 1234", mem_addr, mix_out);
        end
        do_frame(0);
        checks++;
        if (mem_addr !== 15'h204A) begin
            errors++;
            $display("FAIL single_tick2 got %h want 204a", mem_addr);
        end
    endtask

    task automatic test_saturation();
        key_on = 4'b1111; key_val = 16'h3210; wave_sel = 8'b1110_0100;
        for (int v = 0; v < NV; v++) tb_dout[v] = 16'h0060;
        do_frame(0);
        checks++;
        if (mix_out !== 16'h7FFF) begin
            errors++;
            $display("FAIL sat_pos got %h want 7fff", mix_out);
        end
        for (int v = 0; v < NV; v++) tb_dout[v] = 16'h00A0;
        do_frame(0);
        checks++;
        if (mix_out !== 16'h8000) begin
            errors++;
            $display("FAIL sat_neg got %h want 8000", mix_out);
        end
        key_on = 4'b0011; tb_dout[0] = 16'h0001; tb_dout[1] = 16'h00FF;
        do_frame(0);
        checks++;
        if (mix_out !== 16'h0000) begin
            errors++;
            $display("FAIL mix_cancel got %h want 0000", mix_out);
        end
    endtask

    task automatic test_release_invalid();
        int held;
        int start;
        int rd0;
        int n;
        key_on = 4'b0011; key_val = 16'h0050; wave_sel = 8'b0000_1001;
        tb_dout[0] = 16'h0100; tb_dout[1] = 16'h0200; mem_delay = 1;
        repeat (3) do_frame(0);
        held = model_pos[1];
        // Voice 0 released, voice 1 given an out-of-range note: no reads at all.
        key_on = 4'b0010; key_val = 16'h00D0;
        start = mv_count;
        rd0 = rd_count;
        model_frame();
        @(posedge clk_50); #1 sample_tick = 1'b1;
        @(posedge clk_50); #1 sample_tick = 1'b0;
        n = 1;
        while (mix_valid !== 1'b1 && n < 100) begin
            @(posedge clk_50); #1;
            n++;
        end
        checks++;
        if (n + 1 != 10) begin
            errors++;
            $display("FAIL idle_latency got %0d want 10 cycles", n + 1);
        end
        wait_mix(start);
        checks++;
        if (rd_count != rd0) begin
            errors++;
            $display("FAIL no_read got %0d reads want 0", rd_count - rd0);
        end
        key_on = 4'b0011; key_val = 16'h0000;
        do_frame(0);
        checks++;
        if (mem_addr !== {wave_sel[3:2], 13'(held)}) begin
            errors++;
            $display("FAIL pos_held got %h want %h", mem_addr, {wave_sel[3:2], 13'(held)});
        end
    endtask

    task automatic test_phase_wrap();
        key_on = 4'b0000; key_val = 16'h000C; wave_sel = 8'b0000_0010;
        tb_dout[0] = 16'h0010; mem_delay = 1;
        do_frame(0);
        key_on = 4'b0001;
        // 53 x 148 + 78 + 104 + 124 = 8150
        repeat (53) do_frame(0);
        key_val = 16'h0001; do_frame(0);
        key_val = 16'h0006; do_frame(0);
        key_val = 16'h0009; do_frame(0);
        key_val = 16'h000C; do_frame(0);
        do_frame(0);
        checks++;
        if (mem_addr[12:0] !== 13'd106) begin
            errors++;
            $display("FAIL phase_wrap got %0d want 106", mem_addr[12:0]);
        end
    endtask

    task automatic test_overrun();
        int start;
        key_on = 4'b0011; key_val = 16'h0042; wave_sel = 8'b0000_0110;
        tb_dout[0] = 16'h0300; tb_dout[1] = 16'h0400; mem_delay = 2;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pre got %b want 0", overrun);
        end
        start = mv_count;
        do_frame(1);
        repeat (30) @(posedge clk_50);
        #1;
        checks++;
        if (overrun !== 1'b1 || mv_count - start != 1) begin
            errors++;
            $display("FAIL overrun got flag %b pulses %0d want 1 1", overrun, mv_count - start);
        end
    endtask

    task automatic test_timeout();
        key_on = 4'b0011; key_val = 16'h0073; wave_sel = 8'b0000_0111;
        tb_nodone = 4'b0001; tb_dout[0] = 16'h7777; tb_dout[1] = 16'h3412;
        checks++;
        if (mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pre got %b want 0", mem_timeout);
        end
        do_frame(0);
        checks++;
        if (mem_timeout !== 1'b1 || mix_out !== 16'h1234) begin
            errors++;
            $display("FAIL timeout got flag %b mix %h want 1 1234", mem_timeout, mix_out);
        end
        tb_nodone = 4'b0000;
    endtask

    task automatic test_reset_midsweep();
        int start;
        key_on = 4'b0001; key_val = 16'h0000; mem_delay = 5;
        start = mv_count;
        model_frame();
        @(posedge clk_50); #1 sample_tick = 1'b1;
        @(posedge clk_50); #1 sample_tick = 1'b0;
        @(posedge clk_50); #1;
        checks++;
        if (mem_rd !== 1'b1) begin
            errors++;
            $display("FAIL rd_timing got %b want 1", mem_rd);
        end
        #1 daclrck = 1'b1;
        #1;
        checks++;
        if (mem_rd !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL async_abort got rd %b busy %b ovr %b tmo %b want 0 0 0 0",
                     mem_rd, busy, overrun, mem_timeout);
        end
        repeat (3) @(posedge clk_50);
        #1 daclrck = 1'b0;
        exp_addr_q.delete();
        exp_mix_q.delete();
        mem_q.delete();
        for (int v = 0; v < NV; v++) model_pos[v] = 0;
        repeat (30) @(posedge clk_50);
        #1;
        checks++;
        if (mv_count != start) begin
            errors++;
            $display("FAIL abort_no_mix got %0d pulses want 0", mv_count - start);
        end
    endtask

    initial begin
        daclrck = 1'b1; sample_tick = 1'b0;
        key_on = '0; key_val = '0; wave_sel = '0; tb_nodone = '0;
        for (int v = 0; v < NV; v++) begin
            model_pos[v] = 0;
            tb_dout[v] = 16'h0;
        end
        test_reset();
        test_single_voice();
        test_saturation();
        test_release_invalid();
        test_phase_wrap();
        test_overrun();
        test_timeout();
        test_reset_midsweep();
        checks++;
        if (exp_addr_q.size() != 0 || exp_mix_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d reads %0d mixes pending want 0 0",
                     exp_addr_q.size(), exp_mix_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
- Time-multiplexes the single dpram_ctrl read port among NUM_VOICES independent wavetable voices to give polyphony.
- On each sample_tick it sweeps the voices in order. For each active voice it issues one read, accumulates the returned sample, then advances that voice's phase by its scale.
- After the sweep it emits one saturated 16-bit mix sample toward the codec serializer.

Parameters:
- NUM_VOICES, 4, number of voices swept per sample frame (power of 2, 2..8).
- POS_W, 13, phase/position width; wave address = {wave_sel, position}.
- TIMEOUT, 63, max clk_50 cycles to wait for mem_done before abandoning a read.

Ports:
- clk_50  in  1  system clock, 50 MHz.
- daclrck  in  1  reset, asynchronous, active-high.
- sample_tick  in  1  one-cycle strobe in clk_50 domain marking a new sample frame.
- key_on  in  NUM_VOICES  per-voice key pressed.
- key_val  in  4*NUM_VOICES  per-voice note index 0-12 (voice v at [4v+3:4v]).
- wave_sel  in  2*NUM_VOICES  per-voice waveform select.
- mem_addr  out  2+POS_W  read address to dpram_ctrl A.
- mem_rd  out  1  one-cycle read request to dpram_ctrl RD.
- mem_done  in  1  dpram_ctrl Done; read data valid this cycle.
- mem_dout  in  16  dpram_ctrl Dout, little-endian byte order.
- mix_out  out  16  signed mixed sample, big-endian-corrected, held between frames.
- mix_valid  out  1  one-cycle pulse when mix_out updates.
- busy  out  1  high while a sweep is in progress.
- overrun  out  1  sticky: sample_tick arrived while busy.
- mem_timeout  out  1  sticky: a read exceeded TIMEOUT.

Behaviour:
- Reset (daclrck high): state IDLE. All positions, mix_out, accumulator and voice index are 0. mem_rd, mix_valid, busy, overrun and mem_timeout are 0. mem_addr is 0.
- FSM states: IDLE, ISSUE, WAIT, ACCUM, NEXT, FINISH.
- IDLE: on sample_tick, snapshot key_on, key_val and wave_sel into registers, clear accumulator, set v=0, go to ISSUE. busy is high from the next cycle until IDLE is re-entered.
- ISSUE: voice v is active if key_on[v]=1 and key_val[v]<=12.
  - Active: drive mem_addr={wave_sel[v], pos[v]}, pulse mem_rd for exactly 1 cycle, clear the timeout counter, go to WAIT.
  - Inactive: go directly to NEXT with no read.
- mem_addr holds its value from ISSUE until the next ISSUE.
- WAIT: on mem_done, capture sample s={mem_dout[7:0], mem_dout[15:8]} and go to ACCUM.
- WAIT timeout: if the counter reaches TIMEOUT with no mem_done, set s=0, set mem_timeout, go to ACCUM.
- WAIT, done vs. timeout on the same cycle: mem_done on that cycle wins.
- ACCUM: acc += sign-extend(s). acc width is 16+log2(NUM_VOICES), so it cannot overflow.
- NEXT, phase update:
  - Active voice: pos[v] = (pos[v] + scale[key_val[v]]) mod 2^POS_W (natural wrap).
  - key_on[v]=0 (snapshot): pos[v] = 0.
  - key_on[v]=1 with key_val>12: pos[v] holds.
- NEXT, sequencing: if v==NUM_VOICES-1 go to FINISH, else v++ and go to ISSUE.
- FINISH: mix_out = acc saturated to [-32768, 32767]. mix_valid=1 for this one cycle. Return to IDLE.
- Inputs changing mid-sweep have no effect; only the snapshot is used.
- sample_tick while busy is ignored (no restart, frame dropped) and sets overrun. overrun and mem_timeout clear only on reset.
- Reset mid-sweep aborts immediately. No mix_valid is produced. mem_rd deasserts asynchronously.
- A mem_done outside WAIT is ignored.
- Latency, tick to mix_valid: 1 + per voice (active: 3 + wait cycles; inactive: 2) + 1. With NUM_VOICES=4, all inactive: 10 cycles.
- Scale table (note 0..12): 74, 78, 83, 88, 93, 99, 104, 111, 117, 124, 132, 139, 148.

Decomposition:
- Package wavetable_pkg holds:
  - the scale table as a constant array of 13 8-bit values;
  - the FSM state enum;
  - NOTE_MAX=12;
  - a byte-swap function.
- One sub-module, voice_phase_bank, holds the NUM_VOICES position registers. It has an indexed read port and an update port taking (v, mode: add-scale/clear/hold). The FSM, accumulator and saturation stay in voice_scheduler.

Test Plan:
- Reset then idle: daclrck=1 for 3 cycles, then release, then no tick. Required: all outputs 0, busy=0, mix_out=0.
- Single voice:
  - Stimulus: voice 0 key_on, key_val=0, wave_sel=1; memory model returns Done 2 cycles after RD with Dout=16'h3412.
  - Tick 1: mem_addr=15'h2000; mix_out=16'h1234; mix_valid 1 cycle.
  - Tick 2: mem_addr=15'h204A.
- Saturation and mixing:
  - All 4 voices active, each returning byte-swapped 16'h6000: mix_out=16'h7FFF.
  - All 4 returning 16'hA000: mix_out=16'h8000.
  - Voices returning 16'h0100 and 16'hFF00 (others off): mix_out=16'h0000.
- Phase wrap: voice 0 pos preloaded to 8150, key_val=12. After one frame, pos=8298 mod 8192 = 106; next address low bits = 106.
- Key release and invalid note: key_on[0] drops between frames, so no RD for v0 and pos[0]=0. key_val=13 with key_on=1: no RD, pos held.
- Overrun and timeout:
  - Tick again 2 cycles after the first: overrun=1, exactly one mix_valid.
  - Memory model never asserts Done: mem_timeout=1, that voice contributes 0, sweep completes.
